// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: escrowed credit, programmable prices, greedy
// exact change from a coin inventory, and change/refund streamed over valid/ready.
module vend_ctrl_multi #(
   parameter int unsigned N_PRODUCTS    = 4,
   parameter int unsigned VAL_W         = 10,
   parameter int unsigned CNT_W         = 6,
   parameter int unsigned ESC_W         = 4,
   parameter int unsigned INIT_COINS    = 10,
   parameter int unsigned DEFAULT_PRICE = 10,
   parameter int unsigned MAX_CREDIT    = 400,
   localparam int unsigned PW = (N_PRODUCTS > 1) ? $clog2(N_PRODUCTS) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sel_valid,
   input  logic [PW-1:0]    sel_prod,
   input  logic             price_we,
   input  logic [PW-1:0]    price_idx,
   input  logic [VAL_W-1:0] price_data,
   input  logic             money_valid,
   input  logic [2:0]       money_code,
   output logic             money_accept,
   output logic             money_reject,
   input  logic             cancel,
   output logic             busy,
   output logic [VAL_W-1:0] credit,
   output logic             product_valid,
   output logic [PW-1:0]    product_id,
   output logic             item_valid,
   output logic [2:0]       item_code,
   input  logic             item_ready,
   output logic             vend_fail
);
   localparam int unsigned AW = ((CNT_W > ESC_W) ? CNT_W : ESC_W) + 1;
   localparam int unsigned SW = AW + 1;
   localparam int unsigned QW = (VAL_W > AW) ? VAL_W : AW;
   localparam logic [CNT_W-1:0] INV_MAX = '1;

   typedef enum logic [2:0] {S_IDLE, S_PAY, S_CALC, S_VEND, S_CHANGE, S_REFUND} state_t;

   function automatic logic [VAL_W-1:0] coin_val(input logic [2:0] code);
      case (code)
         3'd0:    return VAL_W'(1);
         3'd1:    return VAL_W'(2);
         3'd2:    return VAL_W'(5);
         3'd3:    return VAL_W'(10);
         3'd4:    return VAL_W'(20);
         3'd5:    return VAL_W'(40);
         3'd6:    return VAL_W'(100);
         default: return VAL_W'(200);
      endcase
   endfunction

   state_t state_q, state_d;
   logic [PW-1:0]    prod_q, prod_d, pid_q, pid_d;
   logic [VAL_W-1:0] credit_q, credit_d, rem_q, rem_d;
   logic [VAL_W-1:0] price_q [N_PRODUCTS];
   logic [VAL_W-1:0] price_d [N_PRODUCTS];
   logic [CNT_W-1:0] inv_q [5];
   logic [CNT_W-1:0] inv_d [5];
   logic [ESC_W-1:0] esc_q [8];
   logic [ESC_W-1:0] esc_d [8];
   logic [AW-1:0]    n_q [5];
   logic [AW-1:0]    n_d [5];
   logic [2:0]       dig_q, dig_d, ic_q, ic_d;
   logic acc_q, acc_d, rej_q, rej_d, pv_q, pv_d, vf_q, vf_d, iv_q, iv_d, busy_q, busy_d;
   logic [AW-1:0]    avail_c, nsel_c;
   logic [VAL_W-1:0] quot_c;
   logic [SW-1:0]    sum_c [5];
   logic             any_c;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         prod_q   <= '0;
         pid_q    <= '0;
         credit_q <= '0;
         rem_q    <= '0;
         dig_q    <= '0;
         ic_q     <= '0;
         {acc_q, rej_q, pv_q, vf_q, iv_q, busy_q} <= '0;
         for (int i = 0; i < N_PRODUCTS; i++) price_q[i] <= VAL_W'(DEFAULT_PRICE);
         for (int i = 0; i < 5; i++) begin
            inv_q[i] <= CNT_W'(INIT_COINS);
            n_q[i]   <= '0;
         end
         for (int i = 0; i < 8; i++) esc_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         prod_q   <= prod_d;
         pid_q    <= pid_d;
         credit_q <= credit_d;
         rem_q    <= rem_d;
         dig_q    <= dig_d;
         ic_q     <= ic_d;
         {acc_q, rej_q, pv_q, vf_q, iv_q, busy_q} <= {acc_d, rej_d, pv_d, vf_d, iv_d, busy_d};
         price_q  <= price_d;
         inv_q    <= inv_d;
         n_q      <= n_d;
         esc_q    <= esc_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      prod_d   = prod_q;
      pid_d    = '0;
      credit_d = credit_q;
      rem_d    = rem_q;
      dig_d    = dig_q;
      price_d  = price_q;
      inv_d    = inv_q;
      esc_d    = esc_q;
      n_d      = n_q;
      {acc_d, rej_d, pv_d, vf_d} = '0;
      avail_c  = AW'(inv_q[dig_q]) + AW'(esc_q[dig_q]);
      quot_c   = '0;
      nsel_c   = '0;
      any_c    = 1'b0;
      iv_d     = 1'b0;
      ic_d     = '0;
      for (int i = 0; i < 5; i++) sum_c[i] = SW'(inv_q[i]) + SW'(esc_q[i]) - SW'(n_q[i]);

      case (state_q)
         S_IDLE: begin
            rej_d = money_valid;
            if (price_we && (32'(price_idx) < N_PRODUCTS)) price_d[price_idx] = price_data;
            if (sel_valid && (32'(sel_prod) < N_PRODUCTS)) begin
               prod_d  = sel_prod;
               state_d = S_PAY;
            end
         end
         S_PAY: begin
            if (cancel) begin
               rej_d   = money_valid;
               state_d = S_REFUND;
            end else if (credit_q >= price_q[prod_q]) begin
               rej_d   = money_valid;
               rem_d   = credit_q - price_q[prod_q];
               dig_d   = 3'd4;
               for (int i = 0; i < 5; i++) n_d[i] = '0;
               state_d = S_CALC;
            end else if (money_valid) begin
               if (((VAL_W+1)'(credit_q) + (VAL_W+1)'(coin_val(money_code)) > (VAL_W+1)'(MAX_CREDIT))
                   || (esc_q[money_code] == '1)) begin
                  rej_d = 1'b1;
               end else begin
                  acc_d                = 1'b1;
                  esc_d[money_code]    = esc_q[money_code] + ESC_W'(1);
                  credit_d             = credit_q + coin_val(money_code);
               end
            end
         end
         S_CALC: begin
            // Constant divisors per denomination keep this a set of fixed dividers.
            rej_d = money_valid;
            case (dig_q)
               3'd4:    quot_c = rem_q / VAL_W'(20);
               3'd3:    quot_c = rem_q / VAL_W'(10);
               3'd2:    quot_c = rem_q / VAL_W'(5);
               3'd1:    quot_c = rem_q / VAL_W'(2);
               default: quot_c = rem_q;
            endcase
            nsel_c = (QW'(quot_c) > QW'(avail_c)) ? avail_c : AW'(quot_c);
            n_d[dig_q] = nsel_c;
            rem_d = rem_q - VAL_W'(VAL_W'(nsel_c) * coin_val(dig_q));
            if (dig_q == 3'd0) begin
               if (rem_d == '0) state_d = S_VEND;
               else begin
                  vf_d    = 1'b1;
                  state_d = S_REFUND;
               end
            end else begin
               dig_d = dig_q - 3'd1;
            end
         end
         S_VEND: begin
            rej_d = money_valid;
            for (int i = 0; i < 5; i++) inv_d[i] = (sum_c[i] > SW'(INV_MAX)) ? INV_MAX : CNT_W'(sum_c[i]);
            for (int i = 0; i < 8; i++) esc_d[i] = '0;
            credit_d = '0;
            pv_d     = 1'b1;
            pid_d    = prod_q;
            state_d  = S_CHANGE;
         end
         S_CHANGE: begin
            rej_d = money_valid;
            if (iv_q && item_ready) n_d[ic_q] = n_q[ic_q] - AW'(1);
            state_d = S_IDLE;
            for (int i = 0; i < 5; i++) if (n_d[i] != '0) state_d = S_CHANGE;
         end
         S_REFUND: begin
            rej_d = money_valid;
            if (iv_q && item_ready) begin
               esc_d[ic_q] = esc_q[ic_q] - ESC_W'(1);
               credit_d    = credit_q - coin_val(ic_q);
            end
            state_d = S_IDLE;
            for (int i = 0; i < 8; i++) if (esc_d[i] != '0) state_d = S_REFUND;
         end
         default: state_d = S_IDLE;
      endcase

      // Present the highest remaining denomination; ascending scan leaves the top one.
      if (state_d == S_CHANGE) begin
         for (int i = 0; i < 5; i++) if (n_d[i] != '0) begin any_c = 1'b1; ic_d = 3'(i); end
      end else if (state_d == S_REFUND) begin
         for (int i = 0; i < 8; i++) if (esc_d[i] != '0) begin any_c = 1'b1; ic_d = 3'(i); end
      end
      iv_d   = any_c;
      busy_d = (state_d != S_IDLE);
   end

   assign money_accept  = acc_q;
   assign money_reject  = rej_q;
   assign busy          = busy_q;
   assign credit        = credit_q;
   assign product_valid = pv_q;
   assign product_id    = pid_q;
   assign item_valid    = iv_q;
   assign item_code     = ic_q;
   assign vend_fail     = vf_q;
endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Scoreboard bench for vend_ctrl_multi: a default build plus an empty-inventory,
// low-ceiling build, observed one at a time through a shared monitor.
module tb_vend_ctrl_multi;
   logic clock = 1'b0;
   logic reset = 1'b0;
   logic sel_valid = 1'b0, price_we = 1'b0, money_valid = 1'b0, cancel = 1'b0, item_ready = 1'b1;
   logic [1:0] sel_prod = '0, price_idx = '0;
   logic [9:0] price_data = '0;
   logic [2:0] money_code = '0;

   logic a_acc, a_rej, a_busy, a_pv, a_iv, a_vf, b_acc, b_rej, b_busy, b_pv, b_iv, b_vf;
   logic [9:0] a_credit, b_credit;
   logic [1:0] a_pid, b_pid;
   logic [2:0] a_ic, b_ic;

   bit sel_dut = 1'b0;
   logic m_acc, m_rej, m_busy, m_pv, m_iv, m_vf;
   logic [9:0] m_credit;
   logic [1:0] m_pid;
   logic [2:0] m_ic;

   always #5 clock = ~clock;

   vend_ctrl_multi dut_a (
      .clock(clock), .reset(reset), .sel_valid(sel_valid), .sel_prod(sel_prod),
      .price_we(price_we), .price_idx(price_idx), .price_data(price_data),
      .money_valid(money_valid), .money_code(money_code), .money_accept(a_acc),
      .money_reject(a_rej), .cancel(cancel), .busy(a_busy), .credit(a_credit),
      .product_valid(a_pv), .product_id(a_pid), .item_valid(a_iv), .item_code(a_ic),
      .item_ready(item_ready), .vend_fail(a_vf));

   vend_ctrl_multi #(.INIT_COINS(0), .MAX_CREDIT(50)) dut_b (
      .clock(clock), .reset(reset), .sel_valid(sel_valid), .sel_prod(sel_prod),
      .price_we(price_we), .price_idx(price_idx), .price_data(price_data),
      .money_valid(money_valid), .money_code(money_code), .money_accept(b_acc),
      .money_reject(b_rej), .cancel(cancel), .busy(b_busy), .credit(b_credit),
      .product_valid(b_pv), .product_id(b_pid), .item_valid(b_iv), .item_code(b_ic),
      .item_ready(item_ready), .vend_fail(b_vf));

   assign m_acc    = sel_dut ? b_acc    : a_acc;
   assign m_rej    = sel_dut ? b_rej    : a_rej;
   assign m_busy   = sel_dut ? b_busy   : a_busy;
   assign m_pv     = sel_dut ? b_pv     : a_pv;
   assign m_iv     = sel_dut ? b_iv     : a_iv;
   assign m_vf     = sel_dut ? b_vf     : a_vf;
   assign m_credit = sel_dut ? b_credit : a_credit;
   assign m_pid    = sel_dut ? b_pid    : a_pid;
   assign m_ic     = sel_dut ? b_ic     : a_ic;

   localparam int EV_ACC = 0, EV_REJ = 1, EV_PROD = 2, EV_VFAIL = 3, EV_ITEM = 4;
   typedef struct { int kind; int val; } ev_t;
   ev_t exp_q[$];
   int checks = 0;
   int fails  = 0;

   function automatic string ev_name(input int k);
      case (k)
         EV_ACC:   return "accept";
         EV_REJ:   return "reject";
         EV_PROD:  return "product";
         EV_VFAIL: return "vend_fail";
         default:  return "item";
      endcase
   endfunction

   task automatic push(input int k, input int v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic observe(input int k, input int v);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL unexpected_%s: got value %0d expected no event", ev_name(k), v);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.val != v) begin
            fails++;
            $display("FAIL event: got %s/%0d expected %s/%0d", ev_name(k), v, ev_name(e.kind), e.val);
         end
      end
   endtask

   // Monitor: every DUT output event is matched against the next expected one.
   always @(negedge clock) begin
      if (reset) begin
         if (m_acc) observe(EV_ACC, 0);
         if (m_rej) observe(EV_REJ, 0);
         if (m_pv)  observe(EV_PROD, int'(m_pid));
         if (m_vf)  observe(EV_VFAIL, 0);
         if (m_iv && item_ready) observe(EV_ITEM, int'(m_ic));
      end
   end

   task automatic select(input int p);
      @(posedge clock); #1 sel_valid = 1'b1; sel_prod = 2'(p);
      @(posedge clock); #1 sel_valid = 1'b0;
   endtask

   task automatic write_price(input int idx, input int v);
      @(posedge clock); #1 price_we = 1'b1; price_idx = 2'(idx); price_data = 10'(v);
      @(posedge clock); #1 price_we = 1'b0;
   endtask

   task automatic money(input int c, input bit with_cancel);
      @(posedge clock); #1 money_valid = 1'b1; money_code = 3'(c); cancel = with_cancel;
      @(posedge clock); #1 money_valid = 1'b0; cancel = 1'b0;
   endtask

   task automatic do_cancel();
      @(posedge clock); #1 cancel = 1'b1;
      @(posedge clock); #1 cancel = 1'b0;
   endtask

   task automatic wait_idle(output bit iv_seen);
      int n;
      n = 0;
      iv_seen = 1'b0;
      do begin
         @(negedge clock);
         iv_seen |= m_iv;
         n++;
      end while (m_busy && n < 200);
      chk("idle_timeout_busy", int'(m_busy), 0);
   endtask

   task automatic pulse_reset();
      @(posedge clock); #1 reset = 1'b0;
      @(posedge clock); #1 reset = 1'b1;
   endtask

   initial begin
      bit seen;
      int cnt;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      chk("rst_busy", int'(m_busy), 0);
      chk("rst_credit", int'(m_credit), 0);
      chk("rst_item_valid", int'(m_iv), 0);
      chk("rst_item_code", int'(m_ic), 0);

      // Money while idle is refused.
      push(EV_REJ, 0);
      money(0, 1'b0);

      // Basic vend: price 10, pay 20, one 10-unit coin back.
      push(EV_ACC, 0); push(EV_PROD, 0); push(EV_ITEM, 3);
      select(0);
      money(4, 1'b0);
      @(negedge clock);
      chk("t1_credit", int'(m_credit), 20);
      cnt = 0;
      do begin @(negedge clock); cnt++; end while (!m_pv && cnt < 30);
      chk("t1_accept_to_vend_cycles", cnt, 7);
      wait_idle(seen);
      chk("t1_credit_end", int'(m_credit), 0);
      chk("t1_inv4", int'(dut_a.inv_q[4]), 11);
      chk("t1_inv3", int'(dut_a.inv_q[3]), 9);

      // Cancel refunds escrow highest code first, inventory untouched.
      write_price(2, 25);
      push(EV_ACC, 0); push(EV_ACC, 0); push(EV_ITEM, 2); push(EV_ITEM, 1);
      select(2);
      money(1, 1'b0);
      money(2, 1'b0);
      @(negedge clock);
      chk("t2_credit", int'(m_credit), 7);
      chk("t2_still_paying", int'(m_busy), 1);
      do_cancel();
      wait_idle(seen);
      chk("t2_credit_end", int'(m_credit), 0);
      chk("t2_inv1", int'(dut_a.inv_q[1]), 10);
      chk("t2_inv2", int'(dut_a.inv_q[2]), 10);

      // Cancel beats simultaneous money; only prior escrow comes back.
      push(EV_ACC, 0); push(EV_REJ, 0); push(EV_ITEM, 2);
      select(2);
      money(2, 1'b0);
      money(3, 1'b1);
      wait_idle(seen);
      chk("t6_credit_end", int'(m_credit), 0);

      // Stalled change holds steady, then reset mid-CHANGE.
      item_ready = 1'b0;
      push(EV_ACC, 0); push(EV_PROD, 0);
      select(0);
      money(5, 1'b0);
      cnt = 0;
      do begin @(negedge clock); cnt++; end while (!m_iv && cnt < 30);
      chk("t5_item_valid_up", int'(m_iv), 1);
      chk("t5_item_code", int'(m_ic), 4);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("t5_hold_valid", int'(m_iv), 1);
         chk("t5_hold_code", int'(m_ic), 4);
      end
      pulse_reset();
      @(negedge clock);
      chk("t5_rst_busy", int'(m_busy), 0);
      chk("t5_rst_item_valid", int'(m_iv), 0);
      chk("t5_rst_item_code", int'(m_ic), 0);
      chk("t5_rst_credit", int'(m_credit), 0);
      chk("t5_rst_inv3", int'(dut_a.inv_q[3]), 10);
      chk("t5_rst_inv4", int'(dut_a.inv_q[4]), 10);
      item_ready = 1'b1;

      // Empty-inventory, 50-unit-ceiling build.
      sel_dut = 1'b1;
      pulse_reset();
      push(EV_ACC, 0); push(EV_VFAIL, 0); push(EV_ITEM, 5);
      select(0);
      money(5, 1'b0);
      wait_idle(seen);
      chk("t3_credit_end", int'(m_credit), 0);

      write_price(0, 50);
      push(EV_REJ, 0); push(EV_ACC, 0); push(EV_REJ, 0); push(EV_ACC, 0); push(EV_PROD, 0);
      select(0);
      money(6, 1'b0);
      @(negedge clock);
      chk("t4_credit_after_reject", int'(m_credit), 0);
      money(5, 1'b0);
      money(4, 1'b0);
      money(3, 1'b0);
      @(negedge clock);
      chk("t4_credit_at_ceiling", int'(m_credit), 50);
      wait_idle(seen);
      chk("t4_no_change_item", int'(seen), 0);
      chk("t4_credit_end", int'(m_credit), 0);

      repeat (5) @(negedge clock);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
